// File: rtl/axis_resizer.sv
// axis_resizer: rational-ratio AXI-Stream width converter (gearbox).
// Repacks DWIDTH_IN-bit words into DWIDTH_OUT-bit words through a subword
// buffer of N_IN+N_OUT subwords, preserving subword order and tlast framing.
// Optional build macro AXIS_RESIZER_ZERO_PAD_EN: when defined, the padding
// subwords of a packet's final word are forced to zero; otherwise they carry
// stale buffer contents.
module axis_resizer #(
    parameter int unsigned DWIDTH_IN  = 24,
    parameter int unsigned DWIDTH_OUT = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DWIDTH_IN-1:0]  data_in_data,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic                  data_in_last,
    output logic [DWIDTH_OUT-1:0] data_out_data,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    localparam int unsigned W     = gcd(DWIDTH_IN, DWIDTH_OUT);
    localparam int unsigned N_IN  = DWIDTH_IN / W;
    localparam int unsigned N_OUT = DWIDTH_OUT / W;
    localparam int unsigned CAP   = N_IN + N_OUT;
    localparam int unsigned BW    = CAP * W;
    localparam int unsigned FW    = $clog2(CAP + 1);
    localparam int unsigned FW1   = FW + 1;

    // Subword 0 (oldest) sits at bits [W-1:0]; the output word is the low slice.
    logic [BW-1:0]         sub_q;
    logic [BW-1:0]         sub_d;
    logic [FW-1:0]         fill_q;
    logic [FW-1:0]         fill_d;
    logic [FW-1:0]         fill_rm;
    logic                  flush_q;
    logic                  flush_d;
    logic                  valid_d;
    logic                  last_d;
    logic [DWIDTH_OUT-1:0] data_d;
    logic                  out_hs;
    logic                  in_hs;
    logic                  room;

    // Next-state: remove an output word, append an input word, update flush and outputs.
    always_comb begin
        out_hs  = data_out_valid && data_out_ready;
        fill_rm = fill_q;
        if (out_hs) begin
            fill_rm = (fill_q > FW'(N_OUT)) ? (fill_q - FW'(N_OUT)) : '0;
        end

        room          = ({1'b0, fill_rm} + FW1'(N_IN)) <= FW1'(CAP);
        data_in_ready = room && !flush_q && !reset;
        in_hs         = data_in_valid && data_in_ready;

        sub_d = out_hs ? (sub_q >> DWIDTH_OUT) : sub_q;
        for (int unsigned i = 0; i <= N_OUT; i++) begin
            if (in_hs && (fill_rm == FW'(i))) begin
                sub_d[i*W +: DWIDTH_IN] = data_in_data;
            end
        end

        fill_d = fill_rm + (in_hs ? FW'(N_IN) : '0);

        flush_d = flush_q;
        if (out_hs && data_out_last) begin
            flush_d = 1'b0;
        end
        if (in_hs && data_in_last) begin
            flush_d = 1'b1;
        end

        valid_d = (fill_d >= FW'(N_OUT)) || (flush_d && (fill_d != '0));
        last_d  = flush_d && (fill_d != '0) && (fill_d <= FW'(N_OUT));
        data_d  = sub_d[DWIDTH_OUT-1:0];
`ifdef AXIS_RESIZER_ZERO_PAD_EN
        if (last_d) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (FW'(i) >= fill_d) begin
                    data_d[i*W +: W] = '0;
                end
            end
        end
`endif
    end

    // State and registered outputs; synchronous reset drops all buffered subwords.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q          <= '0;
            fill_q         <= '0;
            flush_q        <= 1'b0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            data_out_data  <= '0;
        end else begin
            sub_q          <= sub_d;
            fill_q         <= fill_d;
            flush_q        <= flush_d;
            data_out_valid <= valid_d;
            data_out_last  <= last_d;
            data_out_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_axis_resizer.sv
// Testbench for axis_resizer: four instances (24->24, 24->48, 24->8, 24->16)
// with a per-instance expected-word queue and an independent output monitor.
`timescale 1ns/1ps
module tb_axis_resizer;

    localparam int unsigned DIN = 24;
    localparam int unsigned NR  = 4;

`ifdef AXIS_RESIZER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic int unsigned gcd_f(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < NR; g++) begin : gen_r
        localparam int          G    = g;
        localparam int unsigned DOUT = (g == 0) ? 24 : (g == 1) ? 48 : (g == 2) ? 8 : 16;
        localparam int unsigned W    = gcd_f(DIN, DOUT);
        localparam int unsigned NI   = DIN / W;
        localparam int unsigned NO   = DOUT / W;

        logic            rst = 1'b1;
        logic [DIN-1:0]  in_data = '0;
        logic            in_valid = 1'b0;
        logic            in_last = 1'b0;
        logic            in_ready;
        logic [DOUT-1:0] out_data;
        logic            out_valid;
        logic            out_last;
        logic            out_ready = 1'b0;
        int              rdy_mode = 0;
        bit              done = 1'b0;

        logic [DOUT-1:0] exp_d_q[$];
        logic [DOUT-1:0] exp_m_q[$];
        bit              exp_l_q[$];
        logic [W-1:0]    acc_q[$];

        axis_resizer #(.DWIDTH_IN(DIN), .DWIDTH_OUT(DOUT)) u_dut (
            .clk            (clk),
            .reset          (rst),
            .data_in_data   (in_data),
            .data_in_valid  (in_valid),
            .data_in_ready  (in_ready),
            .data_in_last   (in_last),
            .data_out_data  (out_data),
            .data_out_valid (out_valid),
            .data_out_ready (out_ready),
            .data_out_last  (out_last)
        );

        // Output ready: held low, held high, or random.
        initial forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        // Monitor: scoreboard pop, hold stability, and input stall while flushing.
        initial begin : mon
            bit              flushing;
            bit              holding;
            logic [DOUT-1:0] held_d;
            bit              held_l;
            logic [DOUT-1:0] ed;
            logic [DOUT-1:0] em;
            bit              el;
            flushing = 1'b0;
            holding  = 1'b0;
            held_d   = '0;
            held_l   = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    flushing = 1'b0;
                    holding  = 1'b0;
                end else begin
                    if (flushing)
                        chk($sformatf("r%0d_in_ready_flush", G), 64'(in_ready), 64'd0);
                    if (holding) begin
                        chk($sformatf("r%0d_hold_valid", G), 64'(out_valid), 64'd1);
                        chk($sformatf("r%0d_hold_data", G), 64'(out_data), 64'(held_d));
                        chk($sformatf("r%0d_hold_last", G), 64'(out_last), 64'(held_l));
                    end
                    if (out_valid && out_ready) begin
                        if (exp_d_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL r%0d_unexpected_out actual=%h last=%0d required=none",
                                     G, out_data, out_last);
                        end else begin
                            ed = exp_d_q.pop_front();
                            em = exp_m_q.pop_front();
                            el = exp_l_q.pop_front();
                            chk($sformatf("r%0d_out_data", G), 64'(out_data & em), 64'(ed & em));
                            chk($sformatf("r%0d_out_last", G), 64'(out_last), 64'(el));
                        end
                    end
                    holding = out_valid && !out_ready;
                    held_d  = out_data;
                    held_l  = out_last;
                    if (in_valid && in_ready && in_last)    flushing = 1'b1;
                    if (out_valid && out_ready && out_last) flushing = 1'b0;
                end
            end
        end

        task automatic exp_word(input logic [47:0] d, input logic [47:0] m, input bit l);
            exp_d_q.push_back(DOUT'(d));
            exp_m_q.push_back(DOUT'(m));
            exp_l_q.push_back(l);
        endtask

        // Packet-level packing model used for randomised traffic.
        task automatic model_word(input logic [DIN-1:0] d, input bit l);
            logic [DOUT-1:0] w;
            logic [DOUT-1:0] m;
            int              k;
            for (int i = 0; i < int'(NI); i++) acc_q.push_back(d[i*W +: W]);
            while (acc_q.size() >= int'(NO)) begin
                w = '0;
                for (int i = 0; i < int'(NO); i++) w[i*W +: W] = acc_q.pop_front();
                exp_d_q.push_back(w);
                exp_m_q.push_back('1);
                exp_l_q.push_back(l && (acc_q.size() == 0));
            end
            if (l && (acc_q.size() > 0)) begin
                w = '0;
                m = '0;
                k = acc_q.size();
                for (int i = 0; i < k; i++) begin
                    w[i*W +: W] = acc_q.pop_front();
                    m[i*W +: W] = '1;
                end
                exp_d_q.push_back(w);
                exp_m_q.push_back(ZP ? '1 : m);
                exp_l_q.push_back(1'b1);
            end
        endtask

        task automatic send(input logic [DIN-1:0] d, input bit l, input bit gaps);
            int n;
            bit hs;
            if (gaps) repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            in_data  = d;
            in_last  = l;
            in_valid = 1'b1;
            n  = 0;
            hs = 1'b0;
            while (!hs && n < 500) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL r%0d_send_timeout actual=no_handshake required=handshake", G);
            end
        endtask

        task automatic do_reset();
            rst = 1'b1;
            @(negedge clk);
            chk($sformatf("r%0d_ready_in_reset", G), 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk($sformatf("r%0d_rst_valid", G), 64'(out_valid), 64'd0);
            chk($sformatf("r%0d_rst_last", G), 64'(out_last), 64'd0);
            chk($sformatf("r%0d_rst_data", G), 64'(out_data), 64'd0);
            chk($sformatf("r%0d_rst_ready", G), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (exp_d_q.size() != 0 && n < 4000) begin
                @(posedge clk);
                n++;
            end
            if (exp_d_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL r%0d_drain_timeout actual_left=%0d required=0", G, exp_d_q.size());
                exp_d_q.delete();
                exp_m_q.delete();
                exp_l_q.delete();
            end
            repeat (3) @(posedge clk);
            #1;
        endtask

        // Hand-computed directed vectors for each ratio.
        task automatic run_directed();
            int              n;
            logic [DIN-1:0]  d;
            logic [DIN-1:0]  a;
            logic [DIN-1:0]  b;
            case (G)
                0: begin
                    n = $urandom_range(3, 40);
                    for (int k = 0; k < n; k++) begin
                        d = DIN'($urandom);
                        exp_word(48'(d), 48'hFFFFFF, k == n - 1);
                        send(d, k == n - 1, 1'b0);
                    end
                end
                1: begin
                    for (int j = 0; j < 18; j++) begin
                        a = 24'h5A0000 + DIN'(2 * j);
                        b = 24'h5A0000 + DIN'(2 * j + 1);
                        exp_word({b, a}, 48'hFFFFFF_FFFFFF, 1'b0);
                    end
                    exp_word({24'h000000, 24'h5A0024}, ZP ? 48'hFFFFFF_FFFFFF : 48'h000000_FFFFFF, 1'b1);
                    for (int k = 0; k < 37; k++) send(24'h5A0000 + DIN'(k), k == 36, 1'b0);
                end
                2: begin
                    exp_word(48'hEF, 48'hFF, 1'b0);
                    exp_word(48'hCD, 48'hFF, 1'b0);
                    exp_word(48'hAB, 48'hFF, 1'b1);
                    send(24'hABCDEF, 1'b1, 1'b0);
                end
                default: begin
                    exp_word(48'h1000, 48'hFFFF, 1'b0);
                    exp_word(48'h2211, 48'hFFFF, 1'b0);
                    exp_word(48'h3332, 48'hFFFF, 1'b1);
                    send(24'h111000, 1'b0, 1'b0);
                    send(24'h333222, 1'b1, 1'b0);
                end
            endcase
        endtask

        // Test sequence for this instance.
        initial begin : seq
            int             len;
            logic [DIN-1:0] d;
            @(posedge clk);
            #1;
            do_reset();

            rdy_mode = 1;
            run_directed();
            drain();

            rdy_mode = 2;
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(1, 12);
                for (int k = 0; k < len; k++) begin
                    d = DIN'($urandom);
                    model_word(d, k == len - 1);
                    send(d, k == len - 1, 1'($urandom_range(0, 1)));
                end
            end
            drain();

            rdy_mode = 0;
            send(24'hDEAD01, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            do_reset();
            acc_q.delete();
            rdy_mode = 1;
            model_word(24'hC0FFEE, 1'b0);
            model_word(24'h123456, 1'b1);
            send(24'hC0FFEE, 1'b0, 1'b0);
            send(24'h123456, 1'b1, 1'b0);
            drain();

            done = 1'b1;
        end
    end

    // Wait for all instances, then report.
    initial begin : fin
        int n;
        n = 0;
        while (!(gen_r[0].done && gen_r[1].done && gen_r[2].done && gen_r[3].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60000) begin
            checks++;
            errors++;
            $display("FAIL global_timeout actual=not_done required=done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
